// File: rtl/sync_fifo_top_if.sv
// Producer/consumer handshake bundle for sync_fifo_top.
// The producer and consumer side both sit on the master modport; the FIFO takes the slave modport.
interface sync_fifo_top_if #(
    parameter int data_width = 8
) ();
    logic [data_width-1:0] w_data;
    logic                  w_inc;
    logic                  r_inc;
    logic [data_width-1:0] r_data;
    logic                  wfull;
    logic                  rempty;

    modport master (
        output w_data, w_inc, r_inc,
        input  r_data, wfull, rempty
    );

    modport slave (
        input  w_data, w_inc, r_inc,
        output r_data, wfull, rempty
    );
endinterface

// File: rtl/sync_fifo_top.sv
// Single-clock FIFO with first-word fall-through read data.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
module sync_fifo_top #(
    parameter int data_width    = 8,
    parameter int address_width = 3
) (
    input  logic            w_clk,
    input  logic            wrst_n,
    sync_fifo_top_if.slave  bus
);
    localparam int depth = 1 << address_width;

    logic [data_width-1:0]  mem [depth];
    logic [address_width:0] wptr, rptr, wptr_nxt, rptr_nxt;
    logic                   full_q, empty_q;
    logic                   push, pop;

    // Each request is qualified only by the registered flags, so there is no inc-to-output path.
    assign push     = bus.w_inc & ~full_q;
    assign pop      = bus.r_inc & ~empty_q;
    assign wptr_nxt = wptr + (address_width+1)'(push);
    assign rptr_nxt = rptr + (address_width+1)'(pop);

    always_ff @(posedge w_clk or negedge wrst_n) begin
        if (!wrst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr    <= wptr_nxt;
            rptr    <= rptr_nxt;
            empty_q <= (wptr_nxt == rptr_nxt);
            full_q  <= (wptr_nxt[address_width] != rptr_nxt[address_width]) &&
                       (wptr_nxt[address_width-1:0] == rptr_nxt[address_width-1:0]);
        end
    end

    // Storage is deliberately left out of reset; the pointers alone define what is valid.
    always_ff @(posedge w_clk) begin
        if (push)
            mem[wptr[address_width-1:0]] <= bus.w_data;
    end

    assign bus.r_data = mem[rptr[address_width-1:0]];
    assign bus.wfull  = full_q;
    assign bus.rempty = empty_q;
endmodule

// File: tb/tb_sync_fifo_top.sv
// Randomized/directed bench for sync_fifo_top with a queue-based model and a decoupled monitor.
module tb_sync_fifo_top;
    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;

    logic w_clk = 1'b0;
    logic wrst_n = 1'b0;

    sync_fifo_top_if #(.data_width(DW)) bus ();

    sync_fifo_top #(.data_width(DW), .address_width(AW)) dut (
        .w_clk (w_clk),
        .wrst_n(wrst_n),
        .bus   (bus.slave)
    );

    always #5 w_clk = ~w_clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: exp_q holds words the FIFO should contain in order; cnt is the occupancy.
    logic [DW-1:0] exp_q[$];
    int cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: updates on each accepted operation using its own occupancy.
    initial begin
        bit pa, po;
        forever begin
            @(posedge w_clk or negedge wrst_n);
            if (!wrst_n) begin
                cnt = 0;
                exp_q.delete();
            end else begin
                pa = bus.w_inc && (cnt < DEPTH);
                po = bus.r_inc && (cnt > 0);
                if (pa) exp_q.push_back(bus.w_data);
                cnt = cnt + int'(pa) - int'(po);
            end
        end
    end

    // Monitor: mid-cycle, compare flags and the presented head; retire the head on a pop.
    initial begin
        forever begin
            @(negedge w_clk);
            chk("rempty", {31'd0, bus.rempty}, {31'd0, cnt == 0});
            chk("wfull",  {31'd0, bus.wfull},  {31'd0, cnt == DEPTH});
            if (cnt > 0) begin
                if (exp_q.size() == 0) chk("scoreboard_underrun", 32'd0, 32'd1);
                else begin
                    chk("r_data", {24'd0, bus.r_data}, {24'd0, exp_q[0]});
                    if (bus.r_inc) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step(input bit wi, input bit ri, input logic [DW-1:0] d);
        bus.w_inc  = wi;
        bus.r_inc  = ri;
        bus.w_data = d;
        @(posedge w_clk);
        #1;
    endtask

    initial begin
        bus.w_inc  = 1'b0;
        bus.r_inc  = 1'b0;
        bus.w_data = '0;
        repeat (2) @(posedge w_clk);
        #1;
        chk("reset_rempty", {31'd0, bus.rempty}, 32'd1);
        chk("reset_wfull",  {31'd0, bus.wfull},  32'd0);
        wrst_n = 1'b1;
        repeat (3) step(0, 0, 8'h00);

        // Fill with 1..9; the ninth must be dropped.
        for (int i = 1; i <= 9; i++) step(1, 0, DW'(i));
        chk("fill_full", {31'd0, bus.wfull}, 32'd1);
        // Drain 13 times; the model expects 1..8 then nothing.
        for (int i = 0; i < 13; i++) step(0, 1, 8'h00);
        chk("drain_empty", {31'd0, bus.rempty}, 32'd1);

        // Steady concurrent traffic with four words queued.
        for (int i = 0; i < 4; i++) step(1, 0, DW'(8'h10 + i));
        for (int i = 0; i < 10; i++) step(1, 1, DW'(8'h20 + i));
        repeat (5) step(0, 1, 8'h00);

        // Push+pop at full: pop wins, 0xAA must not be stored.
        for (int i = 0; i < DEPTH; i++) step(1, 0, DW'(8'h30 + i));
        step(1, 1, 8'hAA);
        chk("full_pushpop_wfull", {31'd0, bus.wfull}, 32'd0);
        repeat (DEPTH) step(0, 1, 8'h00);

        // Push+pop at empty: push wins.
        step(1, 1, 8'h55);
        chk("empty_pushpop_rempty", {31'd0, bus.rempty}, 32'd0);
        step(0, 1, 8'h00);

        // 20 words through, more than two pointer wraps.
        for (int i = 0; i < 20; i++) step(1, 1, DW'(8'h60 + i));
        repeat (3) step(0, 1, 8'h00);

        // Asynchronous reset mid-cycle with three words queued.
        for (int i = 0; i < 3; i++) step(1, 0, DW'(8'h80 + i));
        bus.w_inc = 1'b0;
        #2 wrst_n = 1'b0;
        #1;
        chk("async_rst_rempty", {31'd0, bus.rempty}, 32'd1);
        chk("async_rst_wfull",  {31'd0, bus.wfull},  32'd0);
        @(posedge w_clk);
        #1 wrst_n = 1'b1;
        step(1, 0, 8'h99);
        step(1, 1, 8'h9A);
        chk("post_rst_head", {24'd0, bus.r_data}, 32'h9A);
        step(0, 1, 8'h00);
        step(0, 0, 8'h00);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)));
        repeat (DEPTH + 2) step(0, 1, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
